// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//   Drives J/K inputs of an external bank of WIDTH JK flip-flops so that the
//   bank reaches a requested target word. It re-drives up to MAX_RETRY times
//   if the check fails, then raises a sticky error.
//
//   Build option: JK_TOGGLE_DRIVE_EN
//     defined   : every bit that must change is driven j=1,k=1 (toggle)
//     undefined : 0->1 bits get j=1,k=0 and 1->0 bits get j=0,k=1
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset
//     tgt_valid  in   target word offered
//     tgt_ready  out  block can accept a target (IDLE)
//     tgt_data   in   [WIDTH] requested next bank state
//     q_fb       in   [WIDTH] present Q of the external bank
//     j, k       out  [WIDTH] excitation drive (non-zero only in DRIVE)
//     busy       out  high outside IDLE
//     done       out  one-cycle pulse: bank matched target in CHECK
//     err        out  sticky failure, cleared by reset or next accept
//     retry_cnt  out  [2] re-drive attempts used for the current target
module jk_excitation_driver #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       retry_cnt
);

  if (MAX_RETRY > 3) begin : g_bad_max_retry
    $error("MAX_RETRY must not exceed 3");
  end

  localparam logic [1:0] LP_MAX = 2'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_tgt_q;
  logic [1:0]       r_retry;
  logic             r_err;

  logic             w_match;
  logic [WIDTH-1:0] w_diff;

  assign w_match = (q_fb == r_tgt_q);
  assign w_diff  = r_tgt_q ^ q_fb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tgt_q <= '0;
      r_retry <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tgt_valid) begin
            r_tgt_q <= tgt_data;
            r_retry <= '0;
            r_err   <= 1'b0;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_match) begin
            r_state <= S_IDLE;
          end else if (r_retry < LP_MAX) begin
            r_retry <= r_retry + 2'd1;
            r_state <= S_DRIVE;
          end else begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // j/k follow q_fb combinationally so the drive reflects the bank as it is
  // in the DRIVE cycle, including after a partial earlier attempt.
  always_comb begin
    j = '0;
    k = '0;
    if (r_state == S_DRIVE) begin
`ifdef JK_TOGGLE_DRIVE_EN
      j = w_diff;
      k = w_diff;
`else
      j = w_diff & r_tgt_q;
      k = w_diff & q_fb;
`endif
    end
  end

  // done is decoded from the live match so it lands in the CHECK cycle itself.
  assign tgt_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_CHECK) && w_match;
  assign err       = r_err;
  assign retry_cnt = r_retry;

endmodule
